immediate_encoder: RTL

Inverse of the decode-side immediate extender: accepts a base instruction word, a 32-bit immediate and a format select, and scatters the immediate into the instruction's immediate bit positions. It also expands a load-immediate macro into a LUI/ADDI pair. It sits in the boot/debug instruction-injection path, feeding instruction words into instruction memory or the debug fetch port through a valid/ready handshake with one output register.

---
 rtl/immediate_encoder_pkg.sv | 21 ++
 rtl/immediate_encoder_imm_field_packer.sv | 45 ++++
 rtl/immediate_encoder.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/immediate_encoder_pkg.sv
// Shared definitions for the immediate encoder: format select codes,
// the two opcodes produced by the load-immediate expansion, and the
// state type of the LI sequencing FSM.
package immediate_encoder_pkg;

   localparam logic [2:0] SEL_I  = 3'b000;
   localparam logic [2:0] SEL_S  = 3'b001;
   localparam logic [2:0] SEL_B  = 3'b010;
   localparam logic [2:0] SEL_J  = 3'b011;
   localparam logic [2:0] SEL_U  = 3'b111;
   localparam logic [2:0] SEL_LI = 3'b100;

   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_OPIMM = 7'b0010011;

   typedef enum logic {
      IDLE = 1'b0,
      LI2  = 1'b1
   } state_t;

endpackage

// File: rtl/immediate_encoder_imm_field_packer.sv
// Combinational immediate scatter: writes the immediate bits of the
// selected format into a copy of the base instruction. Selects without
// a scatter pattern (LI, illegal codes) pass the base word through.
module imm_field_packer
   import immediate_encoder_pkg::*;
(
   input  logic [31:0] base_instr,
   input  logic [31:0] imm,
   input  logic [2:0]  sel,
   output logic [31:0] packed_instr
);

   // Overwrite only the immediate positions of the chosen format.
   always_comb begin
      packed_instr = base_instr;
      case (sel)
         SEL_I: begin
            packed_instr[31:20] = imm[11:0];
         end
         SEL_S: begin
            packed_instr[31:25] = imm[11:5];
            packed_instr[11:7]  = imm[4:0];
         end
         SEL_B: begin
            packed_instr[31]    = imm[12];
            packed_instr[7]     = imm[11];
            packed_instr[30:25] = imm[10:5];
            packed_instr[11:8]  = imm[4:1];
         end
         SEL_J: begin
            packed_instr[31]    = imm[20];
            packed_instr[19:12] = imm[19:12];
            packed_instr[20]    = imm[11];
            packed_instr[30:21] = imm[10:1];
         end
         SEL_U: begin
            packed_instr[31:12] = imm[31:12];
         end
         default: begin
            packed_instr = base_instr;
         end
      endcase
   end

endmodule

// File: rtl/immediate_encoder.sv
// Immediate encoder for the instruction-injection path. Scatters an
// immediate into a base instruction, or expands the LI macro into an
// ADDI or a LUI/ADDI pair, and presents words through a single output
// register with a valid/ready handshake.
// Optional feature: define IMMEDIATE_RANGE_CHECK_EN to flag immediates
// that do not fit their format (and illegal selects) on Err.
module immediate_encoder
   import immediate_encoder_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        In_valid,
   output logic        In_ready,
   input  logic [31:0] Base_instr,
   input  logic [31:0] Imm,
   input  logic [2:0]  select,
   output logic        Out_valid,
   input  logic        Out_ready,
   output logic [31:0] Instr_out,
   output logic        Err
);

   state_t      state_q, state_d;
   logic        out_valid_q, out_valid_d;
   logic [31:0] instr_q, instr_d;
   logic        err_q, err_d;
   logic [31:0] pend_q, pend_d;

   logic [31:0] packed_word;
   logic        imm_fits12;
   logic [19:0] li_hi;
   logic [11:0] li_lo;
   logic [4:0]  rd;
   logic        li_two;
   logic [31:0] first_word;
   logic [31:0] addi_pend;
   logic        err_calc;
   logic        accept;
   logic        consume;

   imm_field_packer u_packer (
      .base_instr   (Base_instr),
      .imm          (Imm),
      .sel          (select),
      .packed_instr (packed_word)
   );

   // LI split: hi is rounded by adding 0x800, which only carries into
   // bit 12 when Imm[11] is set, so a 20-bit increment gives the wrap.
   always_comb begin
      imm_fits12 = (Imm[31:11] == {21{Imm[31]}});
      rd         = Base_instr[11:7];
      li_lo      = Imm[11:0];
      li_hi      = Imm[31:12] + {19'd0, Imm[11]};
      li_two     = (select == SEL_LI) & ~imm_fits12 & (li_lo != 12'd0);
      addi_pend  = {li_lo, rd, 3'b000, rd, OP_OPIMM};
      first_word = packed_word;
      if (select == SEL_LI) begin
         if (imm_fits12) begin
            first_word = {li_lo, 5'd0, 3'b000, rd, OP_OPIMM};
         end else begin
            first_word = {li_hi, rd, OP_LUI};
         end
      end
   end

`ifdef IMMEDIATE_RANGE_CHECK_EN
   // Flag immediates whose value would be truncated by the format.
   always_comb begin
      err_calc = 1'b0;
      case (select)
         SEL_I, SEL_S: err_calc = ~imm_fits12;
         SEL_B:        err_calc = (Imm[31:12] != {20{Imm[31]}}) | Imm[0];
         SEL_J:        err_calc = (Imm[31:20] != {12{Imm[31]}}) | Imm[0];
         SEL_U:        err_calc = (Imm[11:0] != 12'd0);
         SEL_LI:       err_calc = 1'b0;
         default:      err_calc = 1'b1;
      endcase
   end
`else
   assign err_calc = 1'b0;
`endif

   assign In_ready  = (state_q == IDLE) & (~out_valid_q | Out_ready);
   assign accept    = In_valid & In_ready;
   assign consume   = out_valid_q & Out_ready;
   assign Out_valid = out_valid_q;
   assign Instr_out = instr_q;
   assign Err       = err_q;

   // Next state: load on accept, hold the ADDI half in LI2 until the
   // LUI leaves, and drop valid when a word is consumed with no refill.
   always_comb begin
      state_d     = state_q;
      out_valid_d = out_valid_q;
      instr_d     = instr_q;
      err_d       = err_q;
      pend_d      = pend_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               out_valid_d = 1'b1;
               instr_d     = first_word;
               err_d       = err_calc;
               if (li_two) begin
                  pend_d  = addi_pend;
                  state_d = LI2;
               end
            end else if (consume) begin
               out_valid_d = 1'b0;
            end
         end
         LI2: begin
            if (consume) begin
               out_valid_d = 1'b1;
               instr_d     = pend_q;
               err_d       = 1'b0;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Register update; reset clears the output and abandons any pending ADDI.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         out_valid_q <= 1'b0;
         instr_q     <= 32'd0;
         err_q       <= 1'b0;
         pend_q      <= 32'd0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         instr_q     <= instr_d;
         err_q       <= err_d;
         pend_q      <= pend_d;
      end
   end

endmodule
